condicionador_botoes: RTL and testbench



---
 rtl/condicionador_botoes.sv | 207 ++++++++++++++++++++
 tb/tb_condicionador_botoes.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: push-button conditioning for the stopwatch keys.
// Each channel runs a two-flop synchroniser and then a debounce FSM, and
// produces a clean pressed level plus one-cycle press, release and
// long-press pulses.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, hold_pulse
// repeats every REPEAT_CYCLES cycles after the first long-press pulse.
// When it is undefined, there is one hold_pulse per press.
//
// state        | meaning
// -------------+----------------------------------------------------------
// RELEASED     | key idle, key_level=0
// PRESS_WAIT   | synced key pressed, counting stability before acceptance
// PRESSED      | press accepted, key_level=1, hold timer running
// RELEASE_WAIT | synced key released, counting stability, key_level still 1

module condicionador_botoes #(
  parameter int NUM_BOTOES    = 3,
  parameter int STABLE_CYCLES = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_BOTOES-1:0] key_n_in,
  output logic [NUM_BOTOES-1:0] key_level,
  output logic [NUM_BOTOES-1:0] press_pulse,
  output logic [NUM_BOTOES-1:0] release_pulse,
  output logic [NUM_BOTOES-1:0] hold_pulse
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  // Elaboration-time guard against parameter sets the counters cannot honour.
  if (STABLE_CYCLES < 2 || HOLD_CYCLES <= STABLE_CYCLES || REPEAT_CYCLES < 1) begin : g_param_check
    $error("condicionador_botoes: illegal STABLE/HOLD/REPEAT parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } estado_t;

  logic [NUM_BOTOES-1:0] sync_a;
  logic [NUM_BOTOES-1:0] sync_b;
  logic [NUM_BOTOES-1:0] sync_p;

  // Two-flop synchroniser; reset value 1 means "released" on the active-low input.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_n_in;
      sync_b <= sync_a;
    end
  end

  assign sync_p = ~sync_b;

  for (genvar i = 0; i < NUM_BOTOES; i++) begin : g_canal
    estado_t           estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_done_q, hold_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              holdp_q, holdp_d;
`ifdef AUTO_REPEAT_EN
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    // State, counters and registered outputs of one channel.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        estado_q    <= ST_RELEASED;
        cnt_q       <= '0;
        hold_q      <= '0;
        hold_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        holdp_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_q       <= '0;
`endif
      end else begin
        estado_q    <= estado_d;
        cnt_q       <= cnt_d;
        hold_q      <= hold_d;
        hold_done_q <= hold_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        holdp_q     <= holdp_d;
`ifdef AUTO_REPEAT_EN
        rep_q       <= rep_d;
`endif
      end
    end

    // Next-state, debounce counting and long-press timing.
    always_comb begin
      estado_d    = estado_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_done_d = hold_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      holdp_d     = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d       = rep_q;
`endif

      // The hold timer keeps running through release bounces, so it is
      // evaluated for both "key considered down" states.
      if (estado_q == ST_PRESSED || estado_q == ST_RELEASE_WAIT) begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
        if (hold_q == HOLD_LAST && !hold_done_q) begin
          holdp_d     = 1'b1;
          hold_done_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d       = '0;
`endif
        end
`ifdef AUTO_REPEAT_EN
        else if (hold_done_q) begin
          if (rep_q == REP_LAST) begin
            holdp_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end

      case (estado_q)
        ST_RELEASED: begin
          level_d = 1'b0;
          if (sync_p[i]) begin
            estado_d = ST_PRESS_WAIT;
            cnt_d    = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_p[i]) begin
            estado_d = ST_RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            estado_d    = ST_PRESSED;
            level_d     = 1'b1;
            press_d     = 1'b1;
            hold_d      = '0;
            hold_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PRESSED: begin
          level_d = 1'b1;
          if (!sync_p[i]) begin
            estado_d = ST_RELEASE_WAIT;
            cnt_d    = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          level_d = 1'b1;
          if (sync_p[i]) begin
            estado_d = ST_PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            estado_d    = ST_RELEASED;
            level_d     = 1'b0;
            rel_d       = 1'b1;
            holdp_d     = 1'b0;
            hold_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          estado_d = ST_RELEASED;
          level_d  = 1'b0;
        end
      endcase
    end

    assign key_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign hold_pulse[i]    = holdp_q;
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with STABLE_CYCLES=4,
// HOLD_CYCLES=20, REPEAT_CYCLES=8. Edge numbering in each step starts at 1
// on the first edge that samples the new input (E0); accepted changes show
// up after edge E0+6, i.e. loop index 7.
module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] key_n_in;
  logic [2:0] key_level;
  logic [2:0] press_pulse;
  logic [2:0] release_pulse;
  logic [2:0] hold_pulse;

  int total = 0;
  int bad   = 0;

  condicionador_botoes #(
    .NUM_BOTOES   (3),
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_n_in     (key_n_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse   (hold_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ch0 long press: accepted at k=7, released input after k=62 so the
  // release pulse lands at k=69.
  function automatic logic [2:0] hold_exp_ch0(input int k);
`ifdef AUTO_REPEAT_EN
    return (k >= 27 && ((k - 27) % 8) == 0 && k < 69) ? 3'b001 : 3'b000;
`else
    return (k == 27) ? 3'b001 : 3'b000;
`endif
  endfunction

  initial begin
    reset_n  = 1'b0;
    key_n_in = 3'b000;

    // Reset with all keys held: outputs stay 0.
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("rst_level", key_level, 3'b000);
      check("rst_press", press_pulse, 3'b000);
      check("rst_release", release_pulse, 3'b000);
      check("rst_hold", hold_pulse, 3'b000);
    end
    reset_n = 1'b1;

    // Keys held through reset are new presses on all channels at once.
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("post_rst_press", press_pulse, (k == 7) ? 3'b111 : 3'b000);
      check("post_rst_level", key_level, (k >= 7) ? 3'b111 : 3'b000);
      check("post_rst_release", release_pulse, 3'b000);
      check("post_rst_hold", hold_pulse, 3'b000);
    end

    // Release all channels together.
    key_n_in = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("all_rel_release", release_pulse, (k == 7) ? 3'b111 : 3'b000);
      check("all_rel_level", key_level, (k >= 7) ? 3'b000 : 3'b111);
      check("all_rel_press", press_pulse, 3'b000);
    end

    // Clean press + long press + release on ch0.
    key_n_in = 3'b110;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 62) key_n_in = 3'b111;
      check("ch0_press", press_pulse, (k == 7) ? 3'b001 : 3'b000);
      check("ch0_level", key_level, (k >= 7 && k < 69) ? 3'b001 : 3'b000);
      check("ch0_release", release_pulse, (k == 69) ? 3'b001 : 3'b000);
      check("ch0_hold", hold_pulse, hold_exp_ch0(k));
    end

    // ch1 glitch of 3 cycles: nothing changes.
    key_n_in = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) key_n_in = 3'b111;
      check("glitch_level", key_level, 3'b000);
      check("glitch_press", press_pulse, 3'b000);
      check("glitch_release", release_pulse, 3'b000);
    end

    // ch2 press, release bounce (2 high, 2 low), final release.
    key_n_in = 3'b011;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 10) key_n_in = 3'b111;
      if (k == 12) key_n_in = 3'b011;
      if (k == 24) key_n_in = 3'b111;
      check("bounce_press", press_pulse, (k == 7) ? 3'b100 : 3'b000);
      check("bounce_level", key_level, (k >= 7 && k < 31) ? 3'b100 : 3'b000);
      check("bounce_release", release_pulse, (k == 31) ? 3'b100 : 3'b000);
      check("bounce_hold", hold_pulse, (k == 27) ? 3'b100 : 3'b000);
    end

    // Reset while ch0 is pressed, key kept held.
    key_n_in = 3'b110;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("mid_press", press_pulse, (k == 7) ? 3'b001 : 3'b000);
      check("mid_level", key_level, (k >= 7) ? 3'b001 : 3'b000);
    end
    reset_n = 1'b0;
    tick();
    check("mid_rst_level", key_level, 3'b000);
    check("mid_rst_press", press_pulse, 3'b000);
    check("mid_rst_release", release_pulse, 3'b000);
    check("mid_rst_hold", hold_pulse, 3'b000);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("re_press", press_pulse, (k == 7) ? 3'b001 : 3'b000);
      check("re_level", key_level, (k >= 7) ? 3'b001 : 3'b000);
      check("re_release", release_pulse, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
